// File: rtl/histogram_reader.sv
// histogram_reader: sweeps the histogram RAM after each hist_valid_i pulse, streams {bin, count, cdf}
// beats through a 2-entry buffer and publishes frame total/peak. Define HIST_CDF_EN to build the CDF.
module histogram_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int BINS   = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hist_valid_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_bin_o,
  output logic [DATA_W-1:0] out_count_o,
  output logic [DATA_W-1:0] out_cdf_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overrun_o,
  output logic [DATA_W-1:0] total_count_o,
  output logic [ADDR_W-1:0] peak_bin_o,
  output logic [DATA_W-1:0] peak_count_o
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(BINS - 1);
  localparam int ENT_W = 1 + ADDR_W + 2 * DATA_W;

  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[DATA_W]) sat_add = {DATA_W{1'b1}};
    else           sat_add = s[DATA_W-1:0];
  endfunction

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              infl_q;
  logic [ADDR_W-1:0] infl_bin_q;
  logic [1:0]        cnt_q, cnt_d;
  logic [ENT_W-1:0]  head_q, skid_q, ent_s;
  logic              out_valid_q;
  logic [DATA_W-1:0] sum_q, pk_cnt_q, total_q, peak_cnt_q;
  logic [ADDR_W-1:0] pk_bin_q, peak_bin_q;
  logic              done_q, overrun_q;
  logic              start_s, pop_s, push_s, head_last_s, rd_en_s;
  logic [2:0]        occ_s;
  logic [DATA_W-1:0] sum_nx_s, ent_cdf_s;

  assign start_s     = (state_q == S_IDLE) && hist_valid_i;
  assign pop_s       = out_valid_q && out_ready_i;
  assign push_s      = infl_q;
  assign head_last_s = head_q[ENT_W-1];
  assign sum_nx_s    = sat_add(sum_q, rd_data_i);
  // The beat leaving this cycle frees its slot, so a free-flowing stream keeps one read per cycle.
  assign occ_s   = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop_s};
  assign rd_en_s = (state_q == S_READ) && (occ_s < 3'd2);
  assign cnt_d   = cnt_q + {1'b0, push_s} - {1'b0, pop_s};
`ifdef HIST_CDF_EN
  assign ent_cdf_s = sum_nx_s;
`else
  assign ent_cdf_s = {DATA_W{1'b0}};
`endif
  assign ent_s = {(infl_bin_q == LAST_BIN), infl_bin_q, rd_data_i, ent_cdf_s};

  // Sweep FSM next state and read address.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (hist_valid_i) begin
          state_d = S_READ;
          addr_d  = {ADDR_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (rd_en_s) begin
          addr_d = addr_q + ADDR_W'(1);
          if (addr_q == LAST_BIN) state_d = S_DRAIN;
          else                    state_d = S_READ;
        end else begin
          state_d = S_READ;
        end
      end
      S_DRAIN: begin
        if (done_q) state_d = S_IDLE;
        else        state_d = S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, read pipeline tracking and event pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      addr_q     <= {ADDR_W{1'b0}};
      infl_q     <= 1'b0;
      infl_bin_q <= {ADDR_W{1'b0}};
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      infl_q    <= rd_en_s;
      if (rd_en_s) infl_bin_q <= addr_q;
      done_q    <= pop_s && head_last_s;
      overrun_q <= hist_valid_i && (state_q != S_IDLE);
    end
  end

  // Two-entry buffer; head_q is the registered output beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q       <= 2'd0;
      head_q      <= {ENT_W{1'b0}};
      skid_q      <= {ENT_W{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= (cnt_d != 2'd0);
      case ({push_s, pop_s})
        2'b01: head_q <= skid_q;
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= ent_s;
          else               skid_q <= ent_s;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_q <= ent_s;
          end else begin
            head_q <= skid_q;
            skid_q <= ent_s;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame statistics: accumulate as data lands, publish when the last beat leaves.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q      <= {DATA_W{1'b0}};
      pk_cnt_q   <= {DATA_W{1'b0}};
      pk_bin_q   <= {ADDR_W{1'b0}};
      total_q    <= {DATA_W{1'b0}};
      peak_cnt_q <= {DATA_W{1'b0}};
      peak_bin_q <= {ADDR_W{1'b0}};
    end else begin
      if (start_s) begin
        sum_q    <= {DATA_W{1'b0}};
        pk_cnt_q <= {DATA_W{1'b0}};
        pk_bin_q <= {ADDR_W{1'b0}};
      end else if (push_s) begin
        sum_q <= sum_nx_s;
        if (rd_data_i > pk_cnt_q) begin
          pk_cnt_q <= rd_data_i;
          pk_bin_q <= infl_bin_q;
        end
      end
      if (pop_s && head_last_s) begin
        total_q    <= sum_q;
        peak_cnt_q <= pk_cnt_q;
        peak_bin_q <= pk_bin_q;
      end
    end
  end

  assign rd_en_o       = rd_en_s;
  assign rd_addr_o     = addr_q;
  assign out_valid_o   = out_valid_q;
  assign out_last_o    = head_q[ENT_W-1];
  assign out_bin_o     = head_q[ENT_W-2 -: ADDR_W];
  assign out_count_o   = head_q[2*DATA_W-1 -: DATA_W];
  assign out_cdf_o     = head_q[DATA_W-1:0];
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q;
  assign overrun_o     = overrun_q;
  assign total_count_o = total_q;
  assign peak_bin_o    = peak_bin_q;
  assign peak_count_o  = peak_cnt_q;
endmodule
